// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write scheduler.
// Holds the default widths, the hardwired-zero register number and the slot state encoding.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 16;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of the two writeback sources, the hazard-check read addresses
// and the register-file write port.
interface regfile_write_scheduler_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              s0_valid;
  logic              s0_ready;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_data;
  logic              s1_valid;
  logic              s1_ready;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_hazard1;
  logic              rd_hazard2;
  logic              regWrite;
  logic [ADDR_W-1:0] writeRegister;
  logic [DATA_W-1:0] writeData;
  logic              idle;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output rd_addr1, rd_addr2,
    input  s0_ready, s1_ready, rd_hazard1, rd_hazard2,
    input  regWrite, writeRegister, writeData, idle, wr_count
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  rd_addr1, rd_addr2,
    output s0_ready, s1_ready, rd_hazard1, rd_hazard2,
    output regWrite, writeRegister, writeData, idle, wr_count
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry holding slot for a writeback source.
// Ready depends only on state and grant, so a source can stream one write per cycle.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              in_ready,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  slot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  assign in_ready = (state_q == SLOT_EMPTY) || grant;
  assign accept   = in_valid && in_ready;

  // A grant drains the slot; a same-cycle accept refills it immediately.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (grant) begin
      state_d = SLOT_EMPTY;
    end
    if (accept) begin
      state_d = SLOT_FULL;
      addr_d  = in_addr;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign full = (state_q == SLOT_FULL);
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file's single write port between the ALU and load writeback paths,
// with round-robin arbitration, a registered write stage and read-hazard flags.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                      clk,
  input logic                      reset,
  regfile_write_scheduler_if.slave bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic              full0, full1;
  logic              grant0, grant1, any_grant;
  logic [ADDR_W-1:0] addr0, addr1, gnt_addr;
  logic [DATA_W-1:0] data0, data1, gnt_data;
  logic              rr_q, rr_d;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.s0_valid),
    .in_addr  (bus.s0_addr),
    .in_data  (bus.s0_data),
    .grant    (grant0),
    .in_ready (bus.s0_ready),
    .full     (full0),
    .addr     (addr0),
    .data     (data0)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.s1_valid),
    .in_addr  (bus.s1_addr),
    .in_data  (bus.s1_data),
    .grant    (grant1),
    .in_ready (bus.s1_ready),
    .full     (full1),
    .addr     (addr1),
    .data     (data1)
  );

  // The rr pointer only moves when both slots compete, so a lone source never loses priority.
  always_comb begin
    grant0    = full0 && (!full1 || !rr_q);
    grant1    = full1 && (!full0 || rr_q);
    any_grant = grant0 || grant1;
    rr_d      = (full0 && full1) ? ~rr_q : rr_q;
    gnt_addr  = grant1 ? addr1 : addr0;
    gnt_data  = grant1 ? data1 : data0;
  end

  // Writes to the zero register drain the slot but never assert regWrite or count.
  always_comb begin
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    wr_count_d       = wr_count_q;
    if (any_grant) begin
      write_register_d = gnt_addr;
      write_data_d     = gnt_data;
      if (gnt_addr != ZERO_ADDR) begin
        reg_write_d = 1'b1;
        wr_count_d  = wr_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q             <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      wr_count_q       <= '0;
    end else begin
      rr_q             <= rr_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      wr_count_q       <= wr_count_d;
    end
  end

  function automatic logic hazard_hit(input logic [ADDR_W-1:0] ra);
    return (ra != ZERO_ADDR) &&
           ((full0 && (addr0 == ra)) ||
            (full1 && (addr1 == ra)) ||
            (reg_write_q && (write_register_q == ra)));
  endfunction

  assign bus.rd_hazard1    = hazard_hit(bus.rd_addr1);
  assign bus.rd_hazard2    = hazard_hit(bus.rd_addr2);
  assign bus.regWrite      = reg_write_q;
  assign bus.writeRegister = write_register_q;
  assign bus.writeData     = write_data_q;
  assign bus.wr_count      = wr_count_q;
  assign bus.idle          = !full0 && !full1 && !reg_write_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: reset, single write, contention,
// hazards, zero-register writes, mid-flight reset and streaming from one source.
module tb_regfile_write_scheduler;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  regfile_write_scheduler_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();

  regfile_write_scheduler #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.s0_valid = v0;
    bus.s0_addr  = a0;
    bus.s0_data  = d0;
    bus.s1_valid = v1;
    bus.s1_addr  = a1;
    bus.s1_data  = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("rst_wr_count", 32'(bus.wr_count), 32'd0);
    checkOutput("rst_idle", 32'(bus.idle), 32'd1);
    checkOutput("rst_s0_ready", 32'(bus.s0_ready), 32'd1);
    checkOutput("rst_s1_ready", 32'(bus.s1_ready), 32'd1);
    checkOutput("rst_writeRegister", 32'(bus.writeRegister), 32'd0);
    checkOutput("rst_writeData", bus.writeData, 32'd0);

    // Single write
    applyStimulus(1'b1, 5'd8, 32'h0000_0009, 1'b0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("single_held_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("single_held_idle", 32'(bus.idle), 32'd0);
    tick();
    checkOutput("single_regWrite", 32'(bus.regWrite), 32'd1);
    checkOutput("single_writeRegister", 32'(bus.writeRegister), 32'd8);
    checkOutput("single_writeData", bus.writeData, 32'd9);
    checkOutput("single_wr_count", 32'(bus.wr_count), 32'd1);
    tick();
    checkOutput("single_after_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("single_after_hold_addr", 32'(bus.writeRegister), 32'd8);
    checkOutput("single_after_idle", 32'(bus.idle), 32'd1);

    // Contention: both sources valid every cycle
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    tick();
    checkOutput("cont_first_s0_ready", 32'(bus.s0_ready), 32'd1);
    checkOutput("cont_first_s1_ready", 32'(bus.s1_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("cont_regWrite", 32'(bus.regWrite), 32'd1);
      checkOutput("cont_addr", 32'(bus.writeRegister), (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput("cont_data", bus.writeData, (i % 2 == 0) ? 32'h11 : 32'h22);
      checkOutput("cont_wr_count", 32'(bus.wr_count), 32'(2 + i));
      checkOutput("cont_s0_ready", 32'(bus.s0_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("cont_s1_ready", 32'(bus.s1_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("drain_addr0", 32'(bus.writeRegister), 32'd1);
    checkOutput("drain_count0", 32'(bus.wr_count), 32'd6);
    tick();
    checkOutput("drain_addr1", 32'(bus.writeRegister), 32'd2);
    checkOutput("drain_count1", 32'(bus.wr_count), 32'd7);
    tick();
    checkOutput("drain_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("drain_idle", 32'(bus.idle), 32'd1);

    // Hazard on a held and then staged write
    bus.rd_addr1 = 5'd9;
    bus.rd_addr2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    checkOutput("haz_before_accept", 32'(bus.rd_hazard1), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("haz_held_1", 32'(bus.rd_hazard1), 32'd1);
    checkOutput("haz_held_2", 32'(bus.rd_hazard2), 32'd0);
    tick();
    checkOutput("haz_staged_regWrite", 32'(bus.regWrite), 32'd1);
    checkOutput("haz_staged_addr", 32'(bus.writeRegister), 32'd9);
    checkOutput("haz_staged_1", 32'(bus.rd_hazard1), 32'd1);
    checkOutput("haz_staged_count", 32'(bus.wr_count), 32'd8);
    tick();
    checkOutput("haz_cleared_1", 32'(bus.rd_hazard1), 32'd0);

    // Zero register write
    bus.rd_addr1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    checkOutput("zero_s0_ready", 32'(bus.s0_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("zero_held_idle", 32'(bus.idle), 32'd0);
    checkOutput("zero_no_hazard", 32'(bus.rd_hazard1), 32'd0);
    tick();
    checkOutput("zero_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("zero_wr_count", 32'(bus.wr_count), 32'd8);
    checkOutput("zero_idle", 32'(bus.idle), 32'd1);

    // Reset with both slots holding writes
    bus.rd_addr1 = 5'd3;
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("midrst_full_idle", 32'(bus.idle), 32'd0);
    checkOutput("midrst_full_hazard", 32'(bus.rd_hazard1), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("midrst_idle", 32'(bus.idle), 32'd1);
    checkOutput("midrst_wr_count", 32'(bus.wr_count), 32'd0);
    checkOutput("midrst_hazard", 32'(bus.rd_hazard1), 32'd0);
    tick();
    checkOutput("midrst_after_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("midrst_after_wr_count", 32'(bus.wr_count), 32'd0);

    // Single source streaming with valid held high
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd5, 32'(32'h50 + i), 1'b0, 5'd0, 32'h0);
      checkOutput("stream_s0_ready", 32'(bus.s0_ready), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("stream_count2", 32'(bus.wr_count), 32'd2);
    checkOutput("stream_data1", bus.writeData, 32'h51);
    tick();
    checkOutput("stream_regWrite", 32'(bus.regWrite), 32'd1);
    checkOutput("stream_data2", bus.writeData, 32'h52);
    checkOutput("stream_count3", 32'(bus.wr_count), 32'd3);
    tick();
    checkOutput("stream_end_regWrite", 32'(bus.regWrite), 32'd0);
    checkOutput("stream_end_idle", 32'(bus.idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
